// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
//   I2C target for the camera-config bus. Decodes 4-byte writes
//   [dev addr+W][reg addr][data hi][data lo] and random 16-bit reads
//   [dev addr+W][reg addr] Sr [dev addr+R][data hi][data lo]. Register storage
//   is external: the block issues WR_EN / RD_EN strobes toward it.
//
// Ports
//   CLOCK     in     1   system clock (SCL high/low phases >= 8 CLOCK periods)
//   RESET     in     1   asynchronous, active-low reset
//   I2C_SCLK  in     1   bus clock from the master
//   I2C_SDAT  inout  1   open-drain data, driven 0 or 'z' only
//   REG_ADDR  out    8   latched register address
//   WR_DATA   out   16   write data, valid while WR_EN is high
//   WR_EN     out    1   one-cycle write strobe
//   RD_EN     out    1   one-cycle read request for REG_ADDR
//   RD_DATA   in    16   read data, sampled the cycle after RD_EN
//   BUSY      out    1   high whenever the FSM is not idle
module i2c_slave_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h5D
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic [7:0]  REG_ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_EN,
    output logic        RD_EN,
    input  logic [15:0] RD_DATA,
    output logic        BUSY
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_ACK_DEV, ST_REG_ADDR, ST_ACK_REG,
        ST_WR_HI, ST_ACK_HI, ST_WR_LO, ST_ACK_LO,
        ST_RD_HI, ST_MACK_HI, ST_RD_LO, ST_MACK_LO, ST_WAIT_STOP
    } state_t;

    state_t      state, state_n;
    logic        scl_s1, scl_s2, scl_prev;
    logic        sda_s1, sda_s2, sda_prev;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  rx, rx_n;
    logic [7:0]  hi_byte, hi_n;
    logic [15:0] tx, tx_n;
    logic        rw, rw_n;
    logic        mack, mack_n;
    logic        rd_cap, rd_cap_n;
    logic        sda_oe, sda_oe_n;
    logic [7:0]  reg_addr_n;
    logic [15:0] wr_data_n;
    logic        wr_en_n, rd_en_n;

    // Events are taken from the synchronized copies so SCL and SDA see the
    // same latency and a START/STOP is never confused with a data edge.
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 &  scl_prev;
    assign start_det = scl_s2 & ~sda_s2 &  sda_prev;
    assign stop_det  = scl_s2 &  sda_s2 & ~sda_prev;

    assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
    assign BUSY     = (state != ST_IDLE);

    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_n       = rx;
        hi_n       = hi_byte;
        tx_n       = tx;
        rw_n       = rw;
        mack_n     = mack;
        sda_oe_n   = sda_oe;
        reg_addr_n = REG_ADDR;
        wr_data_n  = WR_DATA;
        wr_en_n    = 1'b0;
        rd_en_n    = 1'b0;
        rd_cap_n   = RD_EN;

        // External storage answers one cycle after RD_EN; load the word then.
        if (rd_cap) tx_n = RD_DATA;

        if (start_det) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_HI, ST_WR_LO: begin
                    if (scl_rise) begin
                        rx_n      = {rx[6:0], sda_s2};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // Byte complete: ACK slot starts on this fall.
                        bit_cnt_n = 4'd0;
                        sda_oe_n  = 1'b1;
                        case (state)
                            ST_DEV_ADDR: begin
                                if (rx[7:1] == DEV_ADDR) begin
                                    state_n = ST_ACK_DEV;
                                    rw_n    = rx[0];
                                    rd_en_n = rx[0];
                                end else begin
                                    state_n  = ST_WAIT_STOP;
                                    sda_oe_n = 1'b0;
                                end
                            end
                            ST_REG_ADDR: begin
                                state_n    = ST_ACK_REG;
                                reg_addr_n = rx;
                            end
                            ST_WR_HI: begin
                                state_n = ST_ACK_HI;
                                hi_n    = rx;
                            end
                            default: begin
                                state_n   = ST_ACK_LO;
                                wr_data_n = {hi_byte, rx};
                                wr_en_n   = 1'b1;
                            end
                        endcase
                    end
                end
                ST_ACK_DEV: begin
                    if (scl_fall) begin
                        if (rw) begin
                            // First read bit goes out on the same fall that ends the ACK.
                            state_n  = ST_RD_HI;
                            sda_oe_n = ~tx[15];
                        end else begin
                            state_n  = ST_REG_ADDR;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                ST_ACK_REG: if (scl_fall) begin state_n = ST_WR_HI;     sda_oe_n = 1'b0; end
                ST_ACK_HI:  if (scl_fall) begin state_n = ST_WR_LO;     sda_oe_n = 1'b0; end
                ST_ACK_LO:  if (scl_fall) begin state_n = ST_WAIT_STOP; sda_oe_n = 1'b0; end
                ST_RD_HI, ST_RD_LO: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt_n = 4'd0;
                            sda_oe_n  = 1'b0;
                            state_n   = (state == ST_RD_HI) ? ST_MACK_HI : ST_MACK_LO;
                        end else begin
                            tx_n     = {tx[14:0], 1'b0};
                            sda_oe_n = ~tx[14];
                        end
                    end
                end
                ST_MACK_HI: begin
                    if (scl_rise) begin
                        mack_n = sda_s2;
                    end else if (scl_fall) begin
                        if (!mack) begin
                            state_n  = ST_RD_LO;
                            tx_n     = {tx[14:0], 1'b0};
                            sda_oe_n = ~tx[14];
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                ST_MACK_LO: if (scl_fall) begin state_n = ST_WAIT_STOP; sda_oe_n = 1'b0; end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which the synchronizer chain relies on.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            // Bus idles high; resetting the sync chain to 1 avoids a phantom START.
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            rx       <= 8'd0;
            hi_byte  <= 8'd0;
            tx       <= 16'd0;
            rw       <= 1'b0;
            mack     <= 1'b1;
            rd_cap   <= 1'b0;
            sda_oe   <= 1'b0;
            REG_ADDR <= 8'd0;
            WR_DATA  <= 16'd0;
            WR_EN    <= 1'b0;
            RD_EN    <= 1'b0;
        end else begin
            scl_s1   <= I2C_SCLK;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= I2C_SDAT;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            rx       <= rx_n;
            hi_byte  <= hi_n;
            tx       <= tx_n;
            rw       <= rw_n;
            mack     <= mack_n;
            rd_cap   <= rd_cap_n;
            sda_oe   <= sda_oe_n;
            REG_ADDR <= reg_addr_n;
            WR_DATA  <= wr_data_n;
            WR_EN    <= wr_en_n;
            RD_EN    <= rd_en_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder
//   Bench acting as I2C master and as the external register store. Expected
//   WR_EN/RD_EN strobes are queued by the stimulus and compared by a monitor;
//   ACK slots, read bytes and latched outputs are compared inline.
module tb_i2c_slave_responder;

    localparam int Q = 5;  // quarter SCL period in CLOCK cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        tb_sda_low = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    wire         sda_bus;
    logic [7:0]  reg_addr;
    logic [15:0] wr_data;
    logic        wr_en, rd_en, busy;

    assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave_responder #(.DEV_ADDR(7'h5D)) dut (
        .CLOCK    (clk),
        .RESET    (rst_n),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .REG_ADDR (reg_addr),
        .WR_DATA  (wr_data),
        .WR_EN    (wr_en),
        .RD_EN    (rd_en),
        .RD_DATA  (rd_data),
        .BUSY     (busy)
    );

    int test_count = 0;
    int fail_count = 0;
    int drive_cycles = 0;

    typedef struct packed {
        logic        is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_strobe(input logic is_wr, input logic [7:0] addr, input logic [15:0] data);
        sb.push_back(exp_t'{is_wr: is_wr, addr: addr, data: data});
    endtask

    // External register store: register 05 holds a fixed pattern.
    always @(posedge clk) begin
        if (wr_en) mem[reg_addr] <= wr_data;
        if (rd_en) rd_data <= (reg_addr == 8'h05) ? 16'hA5C3 : mem[reg_addr];
    end

    // Counts cycles where the slave pulls SDA low while the master releases it.
    always @(negedge clk) begin
        if (!tb_sda_low && sda_bus == 1'b0) drive_cycles <= drive_cycles + 1;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && (wr_en || rd_en)) begin
            if (sb.size() == 0) begin
                test_count++;
                fail_count++;
                $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr=%h data=%h expected no strobe",
                         wr_en, rd_en, reg_addr, wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", 32'(wr_en), 32'(e.is_wr));
                check("strobe_exclusive", 32'(wr_en & rd_en), 32'h0);
                check("strobe_busy", 32'(busy), 32'h1);
                check("strobe_addr", 32'(reg_addr), 32'(e.addr));
                if (e.is_wr) check("strobe_wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0; wait_q();
        scl = 1'b1;        wait_q();
        tb_sda_low = 1'b1; wait_q();
        scl = 1'b0;        wait_q();
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1; wait_q();
        scl = 1'b1;        wait_q();
        tb_sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            tb_sda_low = ~b[i]; wait_q();
            scl = 1'b1;         wait_q(); wait_q();
            scl = 1'b0;         wait_q();
        end
    endtask

    task automatic get_ack(output logic ack);
        tb_sda_low = 1'b0; wait_q();
        scl = 1'b1;        wait_q();
        ack = sda_bus;     wait_q();
        scl = 1'b0;        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic ack;
        send_bits(b);
        get_ack(ack);
        check(name, 32'(ack), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic master_ack, input string name);
        logic [7:0] b;
        b = 8'h00;
        tb_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl = 1'b1; wait_q();
            b[i] = sda_bus; wait_q();
            scl = 1'b0; wait_q();
        end
        tb_sda_low = master_ack; wait_q();
        scl = 1'b1;              wait_q(); wait_q();
        scl = 1'b0;              wait_q();
        tb_sda_low = 1'b0;
        check(name, 32'(b), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_q();

        // Reset state
        check("rst_reg_addr", 32'(reg_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_rd_en", 32'(rd_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sda_released", 32'(sda_bus), 32'h1);

        // 1: plain 4-byte write
        expect_strobe(1'b1, 8'h20, 16'h1234);
        i2c_start();
        write_byte(8'hBA, 1'b0, "t1_ack_dev");
        write_byte(8'h20, 1'b0, "t1_ack_reg");
        write_byte(8'h12, 1'b0, "t1_ack_hi");
        write_byte(8'h34, 1'b0, "t1_ack_lo");
        i2c_stop();
        check("t1_reg_addr", 32'(reg_addr), 32'h20);
        check("t1_wr_data", 32'(wr_data), 32'h1234);
        check("t1_busy", 32'(busy), 32'h0);

        // 2: wrong device address is ignored
        d0 = drive_cycles;
        i2c_start();
        write_byte(8'hB8, 1'b1, "t2_nack_dev");
        write_byte(8'h20, 1'b1, "t2_nack_reg");
        write_byte(8'h12, 1'b1, "t2_nack_hi");
        write_byte(8'h34, 1'b1, "t2_nack_lo");
        check("t2_busy_before_stop", 32'(busy), 32'h1);
        i2c_stop();
        check("t2_sda_never_driven", 32'(drive_cycles - d0), 32'h0);
        check("t2_busy_after_stop", 32'(busy), 32'h0);
        check("t2_reg_addr", 32'(reg_addr), 32'h20);

        // 3: random read of register 05
        expect_strobe(1'b0, 8'h05, 16'h0000);
        i2c_start();
        write_byte(8'hBA, 1'b0, "t3_ack_dev_w");
        write_byte(8'h05, 1'b0, "t3_ack_reg");
        i2c_start();
        write_byte(8'hBB, 1'b0, "t3_ack_dev_r");
        read_byte(8'hA5, 1'b1, "t3_rd_hi");
        read_byte(8'hC3, 1'b0, "t3_rd_lo");
        check("t3_sda_released", 32'(sda_bus), 32'h1);
        i2c_stop();
        check("t3_reg_addr", 32'(reg_addr), 32'h05);
        check("t3_busy", 32'(busy), 32'h0);

        // 4: partial write keeps old data, latches address
        i2c_start();
        write_byte(8'hBA, 1'b0, "t4_ack_dev");
        write_byte(8'h40, 1'b0, "t4_ack_reg");
        write_byte(8'h77, 1'b0, "t4_ack_hi");
        i2c_stop();
        check("t4_reg_addr", 32'(reg_addr), 32'h40);
        check("t4_wr_data", 32'(wr_data), 32'h1234);
        check("t4_busy", 32'(busy), 32'h0);

        // 5: async reset while the slave holds the ACK low
        i2c_start();
        send_bits(8'hBA);
        tb_sda_low = 1'b0;
        wait_q();
        check("t5_slave_acking", 32'(sda_bus), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_sda_released", 32'(sda_bus), 32'h1);
        check("t5_reg_addr", 32'(reg_addr), 32'h0);
        check("t5_wr_data", 32'(wr_data), 32'h0);
        check("t5_wr_en", 32'(wr_en), 32'h0);
        check("t5_rd_en", 32'(rd_en), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        scl = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_q();
        expect_strobe(1'b1, 8'h55, 16'hBEEF);
        i2c_start();
        write_byte(8'hBA, 1'b0, "t5_ack_dev");
        write_byte(8'h55, 1'b0, "t5_ack_reg");
        write_byte(8'hBE, 1'b0, "t5_ack_hi");
        write_byte(8'hEF, 1'b0, "t5_ack_lo");
        i2c_stop();
        check("t5_post_reg_addr", 32'(reg_addr), 32'h55);
        check("t5_post_wr_data", 32'(wr_data), 32'hBEEF);

        // 6: repeated START after reg byte, then a full write
        expect_strobe(1'b1, 8'h22, 16'hABCD);
        i2c_start();
        write_byte(8'hBA, 1'b0, "t6_ack_dev1");
        write_byte(8'h11, 1'b0, "t6_ack_reg1");
        i2c_start();
        write_byte(8'hBA, 1'b0, "t6_ack_dev2");
        write_byte(8'h22, 1'b0, "t6_ack_reg2");
        write_byte(8'hAB, 1'b0, "t6_ack_hi");
        write_byte(8'hCD, 1'b0, "t6_ack_lo");
        i2c_stop();
        check("t6_reg_addr", 32'(reg_addr), 32'h22);
        check("t6_wr_data", 32'(wr_data), 32'hABCD);

        // 7: read with no address phase uses the current REG_ADDR
        expect_strobe(1'b0, 8'h22, 16'h0000);
        i2c_start();
        write_byte(8'hBB, 1'b0, "t7_ack_dev_r");
        read_byte(8'hAB, 1'b1, "t7_rd_hi");
        read_byte(8'hCD, 1'b0, "t7_rd_lo");
        i2c_stop();
        check("t7_reg_addr", 32'(reg_addr), 32'h22);

        // 8: fifth byte is NACKed, no second strobe
        expect_strobe(1'b1, 8'h30, 16'h0102);
        i2c_start();
        write_byte(8'hBA, 1'b0, "t8_ack_dev");
        write_byte(8'h30, 1'b0, "t8_ack_reg");
        write_byte(8'h01, 1'b0, "t8_ack_hi");
        write_byte(8'h02, 1'b0, "t8_ack_lo");
        write_byte(8'h03, 1'b1, "t8_nack_5th");
        i2c_stop();
        check("t8_wr_data", 32'(wr_data), 32'h0102);

        repeat (4) @(negedge clk);
        check("sb_all_strobes_seen", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
